// File: rtl/alu4_pkg.sv
// Definitions shared by alu4 and its sequencer: opcode values and the
// sequencer's state encoding.
package alu4_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_FIX,
        ST_WAIT_MUL,
        ST_MUL_CAP,
        ST_RESP
    } state_t;

    // True for opcodes OP_ADD through OP_MUL.
    function automatic logic is_valid_op(input logic [2:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu4_sequencer.sv
// Initiator for the alu4 init/done protocol: takes one command at a time,
// pulses init, waits for the result and offers it on a response channel.
module alu4_sequencer
    import alu4_pkg::*;
#(
    parameter int NONMUL_LAT  = 2,
    parameter int MUL_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [2:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_init,
    input  logic [7:0] alu_y,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_done,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_overflow,
    output logic       rsp_zero,
    output logic       rsp_err
);

    localparam int MAX_CNT = (MUL_TIMEOUT > NONMUL_LAT) ? MUL_TIMEOUT : NONMUL_LAT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               accept;
    logic               cap_alu;
    logic               cap_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        accept    = 1'b0;
        cap_alu   = 1'b0;
        cap_err   = 1'b0;
        cmd_ready = 1'b0;
        alu_init  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    cnt_nx = '0;
                    if (is_valid_op(cmd_op)) begin
                        state_nx = ST_ISSUE;
                    end else begin
                        cap_err  = 1'b1;
                        state_nx = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                alu_init = 1'b1;
                cnt_nx   = '0;
                state_nx = (alu_opcode == OP_MUL) ? ST_WAIT_MUL : ST_WAIT_FIX;
            end
            ST_WAIT_FIX: begin
                if (cnt == CNT_W'(NONMUL_LAT - 1)) begin
                    cap_alu  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_WAIT_MUL: begin
                // A done seen in the first cycle may be left over from the
                // previous multiply; done takes priority over the timeout.
                if (cnt != '0 && alu_done) begin
                    cnt_nx   = '0;
                    state_nx = ST_MUL_CAP;
                end else if (cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
                    cap_err  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_MUL_CAP: begin
                cap_alu  = 1'b1;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_opcode   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_y        <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                alu_opcode <= cmd_op;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
            end
            if (cap_alu) begin
                rsp_y        <= alu_y;
                rsp_overflow <= alu_overflow;
                rsp_zero     <= alu_zero;
                rsp_err      <= 1'b0;
            end else if (cap_err) begin
                rsp_y        <= '0;
                rsp_overflow <= 1'b0;
                rsp_zero     <= 1'b0;
                rsp_err      <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu4_sequencer.md
Name: alu4_sequencer

Overview:
- Initiator side of the alu4 init/done protocol; sits between a command source (button/switch front end or test host) and alu4.
- Accepts one command at a time over a valid/ready channel and drives alu4 opcode/A/B and a one-cycle init pulse.
- Waits a fixed latency for ADD/SUB/XOR/SHL, or for the multiplier done flag for MUL, then captures Y/overflow/zero.
- Presents the captured result on a valid/ready response channel with an error flag.

Parameters:
- NONMUL_LAT, 2: cycles from init deassertion to result capture for opcodes 000-011.
- MUL_TIMEOUT, 32: maximum cycles spent waiting for alu_done before aborting with an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 XOR, 011 SHL, 100 MUL.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- alu_opcode  out  3  to alu4 opcode.
- alu_a  out  4  to alu4 A.
- alu_b  out  4  to alu4 B.
- alu_init  out  1  to alu4 init; one-cycle pulse.
- alu_y  in  8  from alu4 Y.
- alu_overflow  in  1  from alu4 overflow.
- alu_zero  in  1  from alu4 zero.
- alu_done  in  1  alu4 multiplier done.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  8  captured result.
- rsp_overflow  out  1  captured overflow.
- rsp_zero  out  1  captured zero.
- rsp_err  out  1  1 = invalid opcode or MUL timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0, except cmd_ready=1.
  - Counters cleared.
  - Reset mid-operation abandons the operation: no response is produced and alu_init is forced to 0 immediately.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/a/b into alu_opcode/alu_a/alu_b. These stay stable until the next accept.
  - Opcode 101-111: go to RESP with rsp_y=0, rsp_overflow=0, rsp_zero=0, rsp_err=1. alu_init is never asserted.
  - Otherwise go to ISSUE.
- ISSUE:
  - alu_init=1 for exactly this one cycle.
  - Next state is WAIT_FIX for opcodes 000-011, WAIT_MUL for 100.
- WAIT_FIX:
  - Counter counts NONMUL_LAT cycles.
  - On the final cycle, sample alu_y/alu_overflow/alu_zero into the rsp_* registers with rsp_err=0, then go to RESP.
  - Total latency from accept to rsp_valid = NONMUL_LAT+2 cycles.
- WAIT_MUL:
  - alu_done is ignored in the first cycle after ISSUE, so a stale done from a previous MUL is masked.
  - From the second cycle on, alu_done=1 moves to MUL_CAP.
  - Timeout counter increments each cycle. On reaching MUL_TIMEOUT, go to RESP with rsp_y=0, rsp_overflow=0, rsp_zero=0, rsp_err=1.
  - If done and timeout occur in the same cycle, done wins.
- MUL_CAP:
  - One cycle later, sample alu_y/alu_overflow/alu_zero with rsp_err=0, then go to RESP.
- RESP:
  - rsp_valid=1 and the rsp_* fields are held stable until rsp_ready=1.
  - On handshake, go to IDLE and drop rsp_valid next cycle.
  - cmd_ready=0 here: no command overlap, one outstanding operation.
- cmd_ready is 0 in every state except IDLE.
- The sequencer does no arithmetic. It only captures; result width is 8 bits exactly as produced by alu4.
- The command source may drop cmd_valid while cmd_ready=0 with no effect.

Decomposition:
- Shared package (alu4_pkg), used by both alu4 and alu4_sequencer:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_XOR=010, OP_SHL=011, OP_MUL=100.
  - state encoding for IDLE, ISSUE, WAIT_FIX, WAIT_MUL, MUL_CAP, RESP.
- No sub-module is needed.
- Top-level integration (alu4_system) instantiates alu4_sequencer and alu4 and routes alu4's internal mul_done out as alu_done.

Test Plan:
- ADD 7,4 via alu4_system with rsp_ready=1 -> rsp_y=0x0B, overflow=0, err=0; rsp_valid rises exactly 4 cycles after accept; alu_init high exactly 1 cycle.
- ADD 7,5 then SUB -6,3 back-to-back -> 0x0C with ovf=1, then 0x07 with ovf=1; cmd_ready=0 from accept until the response handshake.
- MUL 9,7 then MUL 15,15 -> rsp_y=0x3F then 0xE1, err=0; second result not corrupted by a stale done.
- Opcode 110 with A=3, B=3 -> rsp_err=1, rsp_y=0x00, alu_init never pulses.
- MUL against a stub holding alu_done=0 -> rsp_err=1 exactly MUL_TIMEOUT cycles into WAIT_MUL; sequencer returns to IDLE after rsp_ready.
- XOR 5,5 with rsp_ready held 0 for 10 cycles -> rsp_valid=1, rsp_y=0x00, rsp_zero=1 stable throughout. Then assert rst low during a MUL -> all outputs 0 immediately, cmd_ready=1, and no response after release.
